uart_fifo_lvl: RTL

Parametrised synchronous FIFO for the UART TX/RX datapaths, replacing the fixed two-entry buffer. It adds configurable depth, an occupancy count, a programmable level threshold for interrupt generation, and synchronous flush. It also adds sticky overflow/underflow error flags. It sits between the UART shift engines and the APB register block; the register block drives `rd`/`flush`/`err_clr` and reads `count`, `thr_hit` and the error flags.

---
 rtl/uart_fifo_lvl.sv | 72 +++++++
 1 files changed

// File: rtl/uart_fifo_lvl.sv
// uart_fifo_lvl: parametrised UART FIFO with occupancy count, level threshold, flush and optional sticky errors (UART_FIFO_ERR_FLAGS_EN)
module uart_fifo_lvl #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  input  logic              wr,
  input  logic [DWIDTH-1:0] w_data,
  input  logic              rd,
  output logic [DWIDTH-1:0] r_data,
  output logic              empty,
  output logic              full,
  output logic [AWIDTH:0]   count,
  input  logic [AWIDTH:0]   thr,
  output logic              thr_hit,
  input  logic              err_clr,
  output logic              ovf,
  output logic              unf
);
  localparam logic [AWIDTH:0] FULL_CNT = {1'b1, {AWIDTH{1'b0}}};
  logic [DWIDTH-1:0] mem [2**AWIDTH];
  logic [AWIDTH-1:0] wptr, rptr;
  logic              we, re;
  assign empty   = count == '0;
  assign full    = count == FULL_CNT;
  assign we      = wr & (~full | rd);
  assign re      = rd & ~empty;
  assign r_data  = mem[rptr];
  assign thr_hit = (thr != '0) && (count >= thr);
  // pointers and occupancy; flush overrides any strobe in the same cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= wptr + AWIDTH'(we);
      rptr  <= rptr + AWIDTH'(re);
      count <= count + (AWIDTH+1)'(we) - (AWIDTH+1)'(re);
    end
  end
  // storage has no reset; a flush-cycle write is discarded
  always_ff @(posedge clk) begin
    if (we && !flush) mem[wptr] <= w_data;
  end
`ifdef UART_FIFO_ERR_FLAGS_EN
  logic ovf_q, unf_q;
  // sticky error flags; a new event beats err_clr in the same cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= (~flush & wr & full & ~rd) | (ovf_q & ~err_clr);
      unf_q <= (~flush & rd & empty) | (unf_q & ~err_clr);
    end
  end
  assign ovf = ovf_q;
  assign unf = unf_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign ovf = 1'b0;
  assign unf = 1'b0;
`endif
endmodule
